// File: rtl/dual_lane_join.sv
// dual_lane_join: receive-side realignment of two independently-valid lanes.
// Each lane is buffered in its own D-entry FIFO. A pair is released through
// the single output handshake only when both lanes hold at least one beat,
// so the k-th accepted A beat always leaves together with the k-th B beat.
//
// Handshake rules (all three interfaces): a transfer happens on a rising
// clock edge where valid && ready are both 1. A source holds its data stable
// while valid && !ready. The ready signals here depend only on registered
// occupancy, never on any valid or on out_ready, so no combinational path
// runs from a valid input to a ready output.
module dual_lane_join #(
    parameter int W = 32,
    parameter int D = 4,
    localparam int CW = $clog2(D) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [W-1:0]  a,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [W-1:0]  b,
    output logic          b_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  a_out,
    output logic [W-1:0]  b_out,
    output logic [CW-1:0] a_count,
    output logic [CW-1:0] b_count
);

    localparam int AW = $clog2(D);

    // Storage is intentionally not reset; occupancy decides what is valid.
    logic [W-1:0]  a_mem [D];
    logic [W-1:0]  b_mem [D];

    logic [AW-1:0] a_wp;
    logic [AW-1:0] a_rp;
    logic [AW-1:0] b_wp;
    logic [AW-1:0] b_rp;

    logic          a_push;
    logic          b_push;
    logic          pop;

    // Ready comes straight from the count register: full lane refuses beats.
    assign a_ready   = (a_count != CW'(D));
    assign b_ready   = (b_count != CW'(D));

    // A pair exists only when both lanes are non-empty; both lanes pop together.
    assign out_valid = (a_count != '0) && (b_count != '0);
    assign pop       = out_valid && out_ready;

    assign a_push    = a_valid && a_ready;
    assign b_push    = b_valid && b_ready;

    // Heads are shown only alongside out_valid so idle outputs read as zero.
    assign a_out     = out_valid ? a_mem[a_rp] : '0;
    assign b_out     = out_valid ? b_mem[b_rp] : '0;

    // Write accepted beats into each lane's storage at its write pointer.
    always_ff @(posedge clk) begin
        if (a_push) a_mem[a_wp] <= a;
        if (b_push) b_mem[b_wp] <= b;
    end

    // Lane A pointers and occupancy; pointers wrap naturally at D (power of two).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_wp    <= '0;
            a_rp    <= '0;
            a_count <= '0;
        end else begin
            if (a_push) a_wp <= a_wp + 1'b1;
            if (pop)    a_rp <= a_rp + 1'b1;
            case ({a_push, pop})
                2'b10:   a_count <= a_count + 1'b1;
                2'b01:   a_count <= a_count - 1'b1;
                default: a_count <= a_count;
            endcase
        end
    end

    // Lane B pointers and occupancy; mirrors lane A, sharing the pair pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_wp    <= '0;
            b_rp    <= '0;
            b_count <= '0;
        end else begin
            if (b_push) b_wp <= b_wp + 1'b1;
            if (pop)    b_rp <= b_rp + 1'b1;
            case ({b_push, pop})
                2'b10:   b_count <= b_count + 1'b1;
                2'b01:   b_count <= b_count - 1'b1;
                default: b_count <= b_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_lane_join.sv
// tb_dual_lane_join: directed vectors for the two-lane realignment buffer.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected output pairs are queued up front per scenario.
module tb_dual_lane_join;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk;
    logic          reset;
    logic          a_valid;
    logic [W-1:0]  a;
    logic          a_ready;
    logic          b_valid;
    logic [W-1:0]  b;
    logic          b_ready;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  a_out;
    logic [W-1:0]  b_out;
    logic [CW-1:0] a_count;
    logic [CW-1:0] b_count;

    int n_total = 0;
    int n_bad   = 0;

    logic [2*W-1:0] exp_q[$];

    dual_lane_join #(.W(W), .D(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a         (a),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b         (b),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .a_count   (a_count),
        .b_count   (b_count)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic av, input logic [W-1:0] ad,
                         input logic bv, input logic [W-1:0] bd,
                         input logic ordy);
        a_valid   = av;
        a         = ad;
        b_valid   = bv;
        b         = bd;
        out_ready = ordy;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every accepted pair must match the head of exp_q
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_extra", 64'(1), 64'(0));
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                check("pair_a", 64'(a_out), 64'(e[2*W-1:W]));
                check("pair_b", 64'(b_out), 64'(e[W-1:0]));
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ka;
        int kb;
        int cyc;
        logic acc_a;
        logic acc_b;

        drive(0, '0, 0, '0, 0);
        reset = 1'b0;

        // reset then idle
        repeat (3) begin
            mid();
            check("rst_out_valid", 64'(out_valid), 64'(0));
            next();
        end
        reset = 1'b1;
        mid();
        check("idle_a_ready", 64'(a_ready), 64'(1));
        check("idle_b_ready", 64'(b_ready), 64'(1));
        check("idle_out_valid", 64'(out_valid), 64'(0));
        check("idle_a_out", 64'(a_out), 64'(0));
        check("idle_b_out", 64'(b_out), 64'(0));
        check("idle_a_count", 64'(a_count), 64'(0));
        check("idle_b_count", 64'(b_count), 64'(0));
        next();

        // aligned stream
        exp_q.push_back({32'h11, 32'hA1});
        exp_q.push_back({32'h22, 32'hA2});
        drive(1, 'h11, 1, 'hA1, 1);
        mid();
        check("al_no_bypass", 64'(out_valid), 64'(0));
        next();
        drive(1, 'h22, 1, 'hA2, 1);
        mid();
        check("al_valid1", 64'(out_valid), 64'(1));
        check("al_a_count1", 64'(a_count), 64'(1));
        next();
        drive(0, '0, 0, '0, 1);
        mid();
        check("al_valid2", 64'(out_valid), 64'(1));
        check("al_a_count_hold", 64'(a_count), 64'(1));
        check("al_b_count_hold", 64'(b_count), 64'(1));
        next();
        mid();
        check("al_drained", 64'(out_valid), 64'(0));
        check("al_a_count0", 64'(a_count), 64'(0));
        check("al_b_count0", 64'(b_count), 64'(0));
        check("al_q_empty", 64'(exp_q.size()), 64'(0));
        next();

        // skew: A three beats ahead of B
        exp_q.push_back({32'h1, 32'h10});
        exp_q.push_back({32'h2, 32'h20});
        exp_q.push_back({32'h3, 32'h30});
        for (int i = 0; i < 3; i++) begin
            drive(1, W'(i + 1), 0, '0, 1);
            mid();
            check("sk_wait", 64'(out_valid), 64'(0));
            next();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, W'((i + 1) * 16), 1);
            mid();
            if (i == 0) begin
                check("sk_a_peak", 64'(a_count), 64'(3));
                check("sk_still_wait", 64'(out_valid), 64'(0));
            end else begin
                check("sk_valid", 64'(out_valid), 64'(1));
            end
            next();
        end
        drive(0, '0, 0, '0, 1);
        mid();
        check("sk_last_valid", 64'(out_valid), 64'(1));
        next();
        mid();
        check("sk_drained", 64'(out_valid), 64'(0));
        check("sk_a_count0", 64'(a_count), 64'(0));
        check("sk_q_empty", 64'(exp_q.size()), 64'(0));
        next();

        // full lane A, then release by B
        for (int i = 1; i <= 5; i++) exp_q.push_back({W'(i), W'(32'hB0 + i)});
        for (int i = 0; i < 4; i++) begin
            drive(1, W'(i + 1), 0, '0, 1);
            mid();
            check("fl_ready", 64'(a_ready), 64'(1));
            next();
        end
        drive(1, 'h5, 0, '0, 1);
        mid();
        check("fl_full_ready", 64'(a_ready), 64'(0));
        check("fl_full_count", 64'(a_count), 64'(4));
        next();
        drive(1, 'h5, 1, 'hB1, 1);
        mid();
        check("fl_held_ready", 64'(a_ready), 64'(0));
        next();
        drive(1, 'h5, 0, '0, 1);
        mid();
        check("fl_pair_valid", 64'(out_valid), 64'(1));
        check("fl_pop_blocked", 64'(a_ready), 64'(0));
        next();
        mid();
        check("fl_ready_back", 64'(a_ready), 64'(1));
        check("fl_count3", 64'(a_count), 64'(3));
        next();
        drive(0, '0, 0, '0, 1);
        mid();
        check("fl_refill", 64'(a_count), 64'(4));
        next();
        for (int i = 2; i <= 5; i++) begin
            drive(0, '0, 1, W'(32'hB0 + i), 1);
            mid();
            next();
        end
        drive(0, '0, 0, '0, 1);
        mid();
        next();
        mid();
        check("fl_a_count0", 64'(a_count), 64'(0));
        check("fl_b_count0", 64'(b_count), 64'(0));
        check("fl_q_empty", 64'(exp_q.size()), 64'(0));
        next();

        // backpressure then streaming across pointer wrap
        for (int i = 0; i < 10; i++) exp_q.push_back({W'(32'h100 + i), W'(32'h200 + i)});
        for (int i = 0; i < 4; i++) begin
            drive(1, W'(32'h100 + i), 1, W'(32'h200 + i), 0);
            mid();
            next();
        end
        drive(0, '0, 0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            mid();
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_a_out", 64'(a_out), 64'(32'h100));
            check("bp_b_out", 64'(b_out), 64'(32'h200));
            check("bp_a_ready", 64'(a_ready), 64'(0));
            check("bp_b_count", 64'(b_count), 64'(4));
            next();
        end
        ka  = 4;
        kb  = 4;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 60) begin
            drive(ka < 10, W'(32'h100 + ka), kb < 10, W'(32'h200 + kb), 1);
            mid();
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            next();
            if (acc_a) ka++;
            if (acc_b) kb++;
            cyc++;
        end
        check("wr_drain", 64'(exp_q.size()), 64'(0));
        drive(0, '0, 0, '0, 1);
        mid();
        check("wr_a_count0", 64'(a_count), 64'(0));
        check("wr_b_count0", 64'(b_count), 64'(0));
        next();
        exp_q.delete();

        // reset mid-operation with counts 2/3
        drive(1, 'h51, 1, 'h61, 0);
        next();
        drive(1, 'h52, 1, 'h62, 0);
        next();
        drive(0, '0, 1, 'h63, 0);
        next();
        drive(0, '0, 0, '0, 0);
        mid();
        check("rm_a_count2", 64'(a_count), 64'(2));
        check("rm_b_count3", 64'(b_count), 64'(3));
        check("rm_valid", 64'(out_valid), 64'(1));
        next();
        reset = 1'b0;
        #1;
        check("rm_async_valid", 64'(out_valid), 64'(0));
        check("rm_async_a_count", 64'(a_count), 64'(0));
        check("rm_async_b_count", 64'(b_count), 64'(0));
        check("rm_async_a_out", 64'(a_out), 64'(0));
        next();
        reset = 1'b1;
        exp_q.push_back({32'h71, 32'h81});
        drive(1, 'h71, 1, 'h81, 1);
        mid();
        check("rm_ready", 64'(a_ready), 64'(1));
        check("rm_empty_after", 64'(out_valid), 64'(0));
        next();
        drive(0, '0, 0, '0, 1);
        mid();
        check("rm_first_pair", 64'(out_valid), 64'(1));
        next();
        mid();
        check("rm_a_count0", 64'(a_count), 64'(0));
        check("rm_q_empty", 64'(exp_q.size()), 64'(0));
        next();

        // final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dual_lane_join.md
Name: dual_lane_join

Overview:
- Receive-side partner of the two-lane delay pipeline.
- Accepts two independently-valid lanes (a, b) that may arrive skewed by up to D beats.
- Buffers each lane in its own small FIFO.
- Releases them only as aligned pairs through a single valid/ready output, restoring the lockstep a/b relationship for downstream pipeline logic.

Parameters:
- W, 32, data width of each lane.
- D, 4, per-lane FIFO depth in entries; power of two, at least 2.
- CW, $clog2(D)+1, occupancy counter width (derived; not overridden).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- a_valid  in  1  lane A beat offered.
- a  in  W  lane A data.
- a_ready  out  1  lane A FIFO can accept a beat.
- b_valid  in  1  lane B beat offered.
- b  in  W  lane B data.
- b_ready  out  1  lane B FIFO can accept a beat.
- out_valid  out  1  an aligned A/B pair is available.
- out_ready  in  1  downstream accepts the pair.
- a_out  out  W  lane A head data.
- b_out  out  W  lane B head data.
- a_count  out  CW  lane A occupancy, 0..D.
- b_count  out  CW  lane B occupancy, 0..D.

Behaviour:
- Design constraints: one clock; reset is asynchronous and active-low.
- Reset state:
  - Read/write pointers and counts are 0.
  - out_valid = 0; a_out = b_out = 0.
  - a_ready = b_ready = 1 from the first cycle after release.
  - Storage contents are don't-care.
- Push:
  - Lane X is written when X_valid && X_ready at a clock edge.
  - The write pointer increments modulo D; wrap from D-1 to 0 is silent.
  - X_ready = (X_count != D). It is driven from the count register only, never from X_valid or out_ready.
- Pop:
  - out_valid = (a_count != 0) && (b_count != 0).
  - A pair is consumed when out_valid && out_ready. Both lanes pop together; read pointers increment modulo D.
  - No single-lane pop exists.
- Data outputs:
  - a_out/b_out present FIFO head entries combinationally while out_valid = 1.
  - Both are forced to 0 while out_valid = 0.
  - Held stable while out_valid && !out_ready.
- Latency: a beat written into an empty lane is visible at the head on the following cycle. There is no same-cycle bypass.
- Count update per lane: +1 on push only, -1 on pop only, unchanged on push and pop in the same cycle.
- Simultaneous push and pop on a full lane: push is blocked because ready = 0. After the pop, ready rises the next cycle.
- Simultaneous push and pop on a lane with count 1 while the other lane is non-empty: the pair pops, the new beat is stored, count stays 1, out_valid stays 1.
- Skew handling:
  - A lane may run ahead by up to D beats; it then stalls via ready = 0 until the other lane catches up.
  - Pair order is strict FIFO per lane: the k-th accepted A beat always pairs with the k-th accepted B beat.
- Reset mid-operation: all buffered beats are discarded immediately (asynchronously); out_valid drops in the same instant.
- X_valid while X_ready = 0: not a protocol error; the beat is simply not accepted. The upstream source must hold it.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release → a_ready=b_ready=1, out_valid=0, a_out=b_out=0, counts=0.
- Aligned stream: push A=0x11,0x22 and B=0xA1,0xA2 on the same cycles, out_ready=1 → pairs (0x11,0xA1) then (0x22,0xA2), each one cycle after push; counts return to 0.
- Skew: push A=1,2,3 on cycles 0-2, B=0x10,0x20,0x30 on cycles 3-5, out_ready=1 → out_valid rises cycle 4; pairs (1,0x10),(2,0x20),(3,0x30); a_count peaks at 3.
- Full lane: push 5 A beats 0x1..0x5 with no B, out_ready=1 → a_ready=0 after 4 accepts, a_count=4, 0x5 held. Then push B=0xB1 → pair (0x1,0xB1) pops, a_ready=1 next cycle, 0x5 accepted; order preserved.
- Backpressure and wrap: D=4, out_ready=0, fill both lanes, hold 3 cycles → a_out/b_out stable, out_valid=1. Then stream 10 pairs with out_ready=1 → all 10 pairs correct in order across pointer wrap.
- Reset mid-operation: with counts 2/3, drop reset for 1 cycle → out_valid=0 immediately; counts=0; the next pushed pair emerges first.
